// File: rtl/hazard_redirect_unit_pkg.sv
// Shared types for the fetch-control producer: widths, scoreboard slot, FSM state.
// Latency: n/a (types and a pure compare helper only).
// Backpressure: n/a.
package hazard_redirect_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ADDR_W     = 32;

  // One in-flight writer tracked by the hazard scoreboard.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } sb_slot_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } fc_state_e;

  // RAW match of one source operand against one slot; r0 never matches.
  function automatic logic raw_match(input sb_slot_t slot,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic uses);
    return slot.valid && (slot.rd == src) && uses && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_redirect_unit_if.sv
// Fetch-control bundle: ID/EX inputs in, redirect/interlock/flush/counters out.
// Latency: n/a (wiring only).
// Backpressure: isDataInterLock freezes PC and IF/ID; no other flow control.
interface hazard_redirect_unit_if
  import hazard_redirect_unit_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_writes_rd;
  logic                  id_is_load;
  logic                  ex_branch_valid;
  logic                  ex_branch_taken;
  logic [ADDR_W-1:0]     ex_branch_target;
  logic                  is_Branch_Taken;
  logic [ADDR_W-1:0]     branchPC;
  logic                  isDataInterLock;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  // Hazard/redirect unit side.
  modport master (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_writes_rd, id_is_load, ex_branch_valid, ex_branch_taken,
           ex_branch_target,
    output is_Branch_Taken, branchPC, isDataInterLock, flush_if_id,
           flush_id_ex, stall_count, flush_count
  );

  // Pipeline side (ID/EX produce, IF consumes).
  modport slave (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_writes_rd, id_is_load, ex_branch_valid, ex_branch_taken,
           ex_branch_target,
    input  is_Branch_Taken, branchPC, isDataInterLock, flush_if_id,
           flush_id_ex, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_redirect_unit_scoreboard.sv
// 3-slot EX/MEM/WB writer scoreboard with RAW compare against the ID instruction.
// Latency: hazard_o is combinational from slots and ID sources; slots shift every clock.
// Backpressure: none; caller drops the insert while stalled or killed.
module hazard_redirect_unit_scoreboard
  import hazard_redirect_unit_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int WB_BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ins_vld_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_is_load_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic                  id_uses_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs2_i,
  output logic                  hazard_o
);

  sb_slot_t ex_q, mem_q, wb_q, ex_d;
  logic     ex_hit, mem_hit, wb_hit;
  logic     unused_load_bits;

  // Older slots only feed address compares; their load flag is informational.
  assign unused_load_bits = mem_q.is_load ^ wb_q.is_load;

  // Next EX slot: the ID writer when it is allowed to issue, otherwise a bubble.
  always_comb begin
    ex_d         = '0;
    ex_d.valid   = ins_vld_i;
    ex_d.rd      = id_rd_i;
    ex_d.is_load = id_is_load_i;
  end

  // Shift writers down the pipe every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // RAW compare; with forwarding only a load still in EX cannot be bypassed.
  always_comb begin
    ex_hit   = raw_match(ex_q,  id_rs1_i, id_uses_rs1_i) | raw_match(ex_q,  id_rs2_i, id_uses_rs2_i);
    mem_hit  = raw_match(mem_q, id_rs1_i, id_uses_rs1_i) | raw_match(mem_q, id_rs2_i, id_uses_rs2_i);
    wb_hit   = raw_match(wb_q,  id_rs1_i, id_uses_rs1_i) | raw_match(wb_q,  id_rs2_i, id_uses_rs2_i);
    hazard_o = 1'b0;
    if (FORWARDING != 0) begin
      hazard_o = ex_hit & ex_q.is_load;
    end else begin
      hazard_o = ex_hit | mem_hit | ((WB_BYPASS == 0) & wb_hit);
    end
  end

endmodule

// File: rtl/hazard_redirect_unit.sv
// Producer of fetch redirect and data-interlock stall, plus pipeline flushes and counters.
// Latency: interlock/flush_id_ex combinational; redirect/flush_if_id registered one clock after EX resolves.
// Backpressure: interlock freezes PC and IF/ID; a taken branch overrides any interlock.
module hazard_redirect_unit
  import hazard_redirect_unit_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  hazard_redirect_unit_if.master fc
);

  fc_state_e         state_q, state_d;
  logic              btk_q, btk_d;
  logic [ADDR_W-1:0] bpc_q, bpc_d;
  logic              fifid_q, fifid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              redirect_go, kill, hazard, interlock, ins_vld;

  // Branches arriving during REDIRECT are wrong-path and cannot start a new redirect.
  assign redirect_go = (state_q == RUN) & fc.ex_branch_valid & fc.ex_branch_taken;
  assign kill        = redirect_go | (state_q == REDIRECT);
  assign interlock   = fc.id_valid & hazard & ~kill;
  assign ins_vld     = fc.id_valid & fc.id_writes_rd & (fc.id_rd != '0) & ~interlock & ~kill;

  hazard_redirect_unit_scoreboard #(
    .FORWARDING (FORWARDING),
    .WB_BYPASS  (WB_BYPASS)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .ins_vld_i     (ins_vld),
    .id_rd_i       (fc.id_rd),
    .id_is_load_i  (fc.id_is_load),
    .id_rs1_i      (fc.id_rs1),
    .id_uses_rs1_i (fc.id_uses_rs1),
    .id_rs2_i      (fc.id_rs2),
    .id_uses_rs2_i (fc.id_uses_rs2),
    .hazard_o      (hazard)
  );

  // Redirect FSM next state, registered redirect outputs and counter updates.
  always_comb begin
    state_d     = state_q;
    btk_d       = 1'b0;
    bpc_d       = bpc_q;
    fifid_d     = 1'b0;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, interlock};
    case (state_q)
      RUN: begin
        if (redirect_go) begin
          state_d     = REDIRECT;
          btk_d       = 1'b1;
          bpc_d       = fc.ex_branch_target;
          fifid_d     = 1'b1;
          flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // State and registered outputs; async reset drops any pending redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      btk_q       <= 1'b0;
      bpc_q       <= '0;
      fifid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      btk_q       <= btk_d;
      bpc_q       <= bpc_d;
      fifid_q     <= fifid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fc.is_Branch_Taken = btk_q;
  assign fc.branchPC        = bpc_q;
  assign fc.flush_if_id     = fifid_q;
  assign fc.isDataInterLock = interlock;
  assign fc.flush_id_ex     = interlock | kill;
  assign fc.stall_count     = stall_cnt_q;
  assign fc.flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_redirect_unit.sv
// Self-checking bench: forwarding and non-forwarding instances driven from one stimulus.
// Latency: inputs applied after negedge, all outputs sampled 1ns later.
// Backpressure: n/a.
module tb_hazard_redirect_unit;
  import hazard_redirect_unit_pkg::*;

  typedef struct packed {
    logic        id_valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        bv;
    logic        bt;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic        lock;
    logic        fidex;
    logic        btk;
    logic [31:0] bpc;
    logic        fifid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic  clk;
  logic  rst;
  stim_t st;
  int    tests;
  int    fails;
  exp_t  expq[$];
  vec_t  vt[$];

  hazard_redirect_unit_if #(.CNT_W(32)) fi ();
  hazard_redirect_unit_if #(.CNT_W(32)) ni ();

  hazard_redirect_unit #(.FORWARDING(1), .WB_BYPASS(1), .CNT_W(32)) u_f (
    .clk(clk), .reset(rst), .fc(fi));
  hazard_redirect_unit #(.FORWARDING(0), .WB_BYPASS(1), .CNT_W(32)) u_n (
    .clk(clk), .reset(rst), .fc(ni));

  assign fi.id_valid = st.id_valid;      assign ni.id_valid = st.id_valid;
  assign fi.id_rs1 = st.rs1;             assign ni.id_rs1 = st.rs1;
  assign fi.id_uses_rs1 = st.u1;         assign ni.id_uses_rs1 = st.u1;
  assign fi.id_rs2 = st.rs2;             assign ni.id_rs2 = st.rs2;
  assign fi.id_uses_rs2 = st.u2;         assign ni.id_uses_rs2 = st.u2;
  assign fi.id_rd = st.rd;               assign ni.id_rd = st.rd;
  assign fi.id_writes_rd = st.wr;        assign ni.id_writes_rd = st.wr;
  assign fi.id_is_load = st.ld;          assign ni.id_is_load = st.ld;
  assign fi.ex_branch_valid = st.bv;     assign ni.ex_branch_valid = st.bv;
  assign fi.ex_branch_taken = st.bt;     assign ni.ex_branch_taken = st.bt;
  assign fi.ex_branch_target = st.tgt;   assign ni.ex_branch_target = st.tgt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ins(input logic [4:0] rd, input logic wr, input logic ld,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    stim_t s;
    s = '0;
    s.id_valid = 1'b1;
    s.rd = rd; s.wr = wr; s.ld = ld;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    return s;
  endfunction

  function automatic stim_t br(input stim_t s0, input logic [31:0] tgt);
    stim_t s;
    s = s0;
    s.bv = 1'b1; s.bt = 1'b1; s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t inv(input stim_t s0);
    stim_t s;
    s = s0;
    s.id_valid = 1'b0;
    return s;
  endfunction

  function automatic exp_t ex(input logic lock, input logic fidex, input logic btk,
                              input logic [31:0] bpc, input logic fifid,
                              input logic [31:0] scnt, input logic [31:0] fcnt);
    exp_t e;
    e.lock = lock; e.fidex = fidex; e.btk = btk; e.bpc = bpc;
    e.fifid = fifid; e.scnt = scnt; e.fcnt = fcnt;
    return e;
  endfunction

  function automatic vec_t mk(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exv);
    tests++;
    if (act !== exv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask

  task automatic check_out(input bit on_n, input exp_t e, input string tag);
    if (on_n) begin
      cmp({tag, ".lock"},  {31'b0, ni.isDataInterLock}, {31'b0, e.lock});
      cmp({tag, ".fidex"}, {31'b0, ni.flush_id_ex},     {31'b0, e.fidex});
      cmp({tag, ".btk"},   {31'b0, ni.is_Branch_Taken}, {31'b0, e.btk});
      cmp({tag, ".bpc"},   ni.branchPC,                 e.bpc);
      cmp({tag, ".fifid"}, {31'b0, ni.flush_if_id},     {31'b0, e.fifid});
      cmp({tag, ".scnt"},  ni.stall_count,              e.scnt);
      cmp({tag, ".fcnt"},  ni.flush_count,              e.fcnt);
    end else begin
      cmp({tag, ".lock"},  {31'b0, fi.isDataInterLock}, {31'b0, e.lock});
      cmp({tag, ".fidex"}, {31'b0, fi.flush_id_ex},     {31'b0, e.fidex});
      cmp({tag, ".btk"},   {31'b0, fi.is_Branch_Taken}, {31'b0, e.btk});
      cmp({tag, ".bpc"},   fi.branchPC,                 e.bpc);
      cmp({tag, ".fifid"}, {31'b0, fi.flush_if_id},     {31'b0, e.fifid});
      cmp({tag, ".scnt"},  fi.stall_count,              e.scnt);
      cmp({tag, ".fcnt"},  fi.flush_count,              e.fcnt);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then pop and compare.
  task automatic step(input stim_t s, input exp_t e, input bit on_n, input string tag);
    exp_t got;
    @(negedge clk);
    st = s;
    expq.push_back(e);
    #1;
    got = expq.pop_front();
    check_out(on_n, got, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    st  = nop();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    st    = nop();

    // Forwarding instance: cycle-by-cycle vectors (outputs as seen during that cycle).
    vt.push_back(mk(nop(),                              ex(0,0,0,32'h00,0,0,0)));
    vt.push_back(mk(ins(5,1,1, 1,1, 0,0),               ex(0,0,0,32'h00,0,0,0)));
    vt.push_back(mk(ins(6,1,0, 5,1, 1,1),               ex(1,1,0,32'h00,0,0,0)));
    vt.push_back(mk(ins(6,1,0, 5,1, 1,1),               ex(0,0,0,32'h00,0,1,0)));
    vt.push_back(mk(nop(),                              ex(0,0,0,32'h00,0,1,0)));
    vt.push_back(mk(br(nop(), 32'h40),                  ex(0,1,0,32'h00,0,1,0)));
    vt.push_back(mk(br(nop(), 32'h99),                  ex(0,1,1,32'h40,1,1,1)));
    vt.push_back(mk(nop(),                              ex(0,0,0,32'h40,0,1,1)));
    vt.push_back(mk(ins(7,1,1, 0,0, 0,0),               ex(0,0,0,32'h40,0,1,1)));
    vt.push_back(mk(br(ins(9,1,1, 2,1, 7,1), 32'h80),   ex(0,1,0,32'h40,0,1,1)));
    vt.push_back(mk(ins(10,1,0, 9,1, 0,0),              ex(0,1,1,32'h80,1,1,2)));
    vt.push_back(mk(nop(),                              ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(0,1,1, 0,0, 0,0),               ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(10,1,0, 0,1, 0,1),              ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(11,1,1, 3,1, 0,0),              ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(12,1,0, 3,1, 11,0),             ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(13,1,0, 12,1, 0,0),             ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(14,1,1, 0,0, 0,0),              ex(0,0,0,32'h80,0,1,2)));
    vt.push_back(mk(ins(15,1,0, 1,1, 14,1),             ex(1,1,0,32'h80,0,1,2)));
    vt.push_back(mk(nop(),                              ex(0,0,0,32'h80,0,2,2)));
    vt.push_back(mk(ins(16,1,1, 0,0, 0,0),              ex(0,0,0,32'h80,0,2,2)));
    vt.push_back(mk(inv(ins(17,1,0, 16,1, 0,0)),        ex(0,0,0,32'h80,0,2,2)));

    // Reset state before any clock edge, both instances.
    #3;
    check_out(1'b0, ex(0,0,0,32'h0,0,0,0), "reset_f");
    check_out(1'b1, ex(0,0,0,32'h0,0,0,0), "reset_n");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s, vt[i].e, 1'b0, $sformatf("vec%0d", i));
    end

    // No forwarding: ALU writer of r3 stalls its consumer through EX and MEM, not WB.
    do_reset();
    step(ins(3,1,0, 0,0, 0,0),             ex(0,0,0,32'h00,0,0,0), 1'b1, "nf_alu");
    step(ins(4,1,0, 3,1, 0,0),             ex(1,1,0,32'h00,0,0,0), 1'b1, "nf_ex");
    step(ins(4,1,0, 3,1, 0,0),             ex(1,1,0,32'h00,0,1,0), 1'b1, "nf_mem");
    step(ins(4,1,0, 3,1, 0,0),             ex(0,0,0,32'h00,0,2,0), 1'b1, "nf_wb");
    step(nop(),                            ex(0,0,0,32'h00,0,2,0), 1'b1, "nf_idle");
    // Killed load r9 must not be tracked: its consumer two cycles later sees no MEM match.
    step(br(ins(9,1,1, 0,0, 0,0), 32'h80), ex(0,1,0,32'h00,0,2,0), 1'b1, "nf_kill");
    step(nop(),                            ex(0,1,1,32'h80,1,2,1), 1'b1, "nf_redir");
    step(ins(20,1,0, 9,1, 0,0),            ex(0,0,0,32'h80,0,2,1), 1'b1, "nf_nokilled");

    // Async reset in the middle of a stall clears slots and counters at once.
    do_reset();
    step(ins(5,1,1, 0,0, 0,0),             ex(0,0,0,32'h00,0,0,0), 1'b1, "rs_ld");
    step(ins(6,1,0, 5,1, 0,0),             ex(1,1,0,32'h00,0,0,0), 1'b1, "rs_st1");
    step(ins(6,1,0, 5,1, 0,0),             ex(1,1,0,32'h00,0,1,0), 1'b1, "rs_st2");
    #2;
    rst = 1'b1;
    #1;
    check_out(1'b1, ex(0,0,0,32'h00,0,0,0), "rs_async");
    @(negedge clk);
    rst = 1'b0;

    // Async reset during REDIRECT drops the redirect; nothing is pending afterwards.
    do_reset();
    step(br(nop(), 32'h40),                ex(0,1,0,32'h00,0,0,0), 1'b0, "rr_br");
    step(nop(),                            ex(0,1,1,32'h40,1,0,1), 1'b0, "rr_redir");
    #2;
    rst = 1'b1;
    #1;
    check_out(1'b0, ex(0,0,0,32'h00,0,0,0), "rr_async");
    @(negedge clk);
    rst = 1'b0;
    step(nop(),                            ex(0,0,0,32'h00,0,0,0), 1'b0, "rr_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
